// File: rtl/chunked_serial_adder.sv
// Multi-cycle unsigned adder: adds WIDTH-bit operands CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow output enabled by defining CHUNKED_ADDER_SIGNED_OVF_EN.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              last;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_sh, b_sh, res_sh;
  logic              carry_reg;
  logic [CHUNK:0]    chunk_sum;
  logic [WIDTH+CHUNK-1:0] res_cat;
  logic [WIDTH-1:0]  res_nxt;

  // Handshake: start is honoured only in IDLE (busy=0); the accepting edge
  // captures A/B/Cin, busy stays high for NCHUNK cycles, and done pulses for
  // exactly one cycle once Sum/Carry hold the new result. start during busy is dropped.

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          last      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // One chunk of the ripple, widened by a bit so the chunk carry-out is kept.
  assign chunk_sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                   + (CHUNK+1)'(carry_reg);
  // New chunk enters at the top; concatenation keeps this legal when CHUNK == WIDTH.
  assign res_cat   = {chunk_sum[CHUNK-1:0], res_sh};
  assign res_nxt   = res_cat[WIDTH+CHUNK-1:CHUNK];

`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
  logic ovf_nxt;
  // On the last chunk the low bits of a_sh/b_sh hold the original operand MSBs.
  assign ovf_nxt = (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                   (chunk_sum[CHUNK-1] != a_sh[CHUNK-1]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      Sum       <= '0;
      Carry     <= 1'b0;
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
      Overflow  <= 1'b0;
`endif
    end else begin
      done <= last;
      if (accept) begin
        a_sh      <= A;
        b_sh      <= B;
        carry_reg <= Cin;
        cnt       <= '0;
        res_sh    <= '0;
      end else if (busy) begin
        a_sh      <= a_sh >> CHUNK;
        b_sh      <= b_sh >> CHUNK;
        res_sh    <= res_nxt;
        carry_reg <= chunk_sum[CHUNK];
        cnt       <= cnt + CW'(1);
        if (last) begin
          Sum      <= res_nxt;
          Carry    <= chunk_sum[CHUNK];
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
          Overflow <= ovf_nxt;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: 16/4 instance and an 8/8 single-chunk instance.
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done;
  logic [15:0] sum;
  logic        carry;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        cin8;
  logic        busy8, done8;
  logic [7:0]  sum8;
  logic        carry8;

`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
  logic        ovf, ovf8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin),
    .busy(busy), .done(done), .Sum(sum), .Carry(carry)
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    , .Overflow(ovf)
`endif
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8)
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    , .Overflow(ovf8)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain; 1: scramble operands after accept; 2: re-assert start while busy
  task automatic run16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic icin, input logic [15:0] es, input logic ec,
                       input logic eovf, input int mode);
    logic [15:0] prev_sum;
    int lat;
    prev_sum = sum;
    a = ia; b = ib; cin = icin; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_after_accept"}, {31'd0, done}, 32'd0);
    if (mode == 1) begin
      a = 16'hAAAA; b = 16'hAAAA; cin = 1'b0;
    end
    lat = 0;
    while (!done && lat < 20) begin
      if (mode == 2 && lat == 1) begin
        start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (!done) check({tag, "_sum_hidden"}, {16'd0, sum}, {16'd0, prev_sum});
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    check({tag, "_carry"}, {31'd0, carry}, {31'd0, ec});
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
`else
    if (eovf !== 1'b0 && eovf !== 1'b1) $display("note: bad overflow vector in %s", tag);
`endif
  endtask

  task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic icin, input logic [7:0] es, input logic ec);
    a8 = ia; b8 = ib; cin8 = icin; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, "_busy"}, {31'd0, busy8}, 32'd1);
    check({tag, "_done_early"}, {31'd0, done8}, 32'd0);
    tick();
    check({tag, "_done"}, {31'd0, done8}, 32'd1);
    check({tag, "_idle"}, {31'd0, busy8}, 32'd0);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
    check({tag, "_carry"}, {31'd0, carry8}, {31'd0, ec});
    tick();
    check({tag, "_done_pulse"}, {31'd0, done8}, 32'd0);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif

    // Full carry ripple through every chunk.
    run16("ffff_p_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("sum_hold", {16'd0, sum}, 32'd0);
    check("carry_hold", {31'd0, carry}, 32'd1);

    // Operands change right after acceptance.
    run16("scramble", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1);
    tick();

    // start while busy ignored; start in done cycle accepted immediately.
    run16("ignore_busy", 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0, 2);
    run16("start_in_done", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
    tick();

    // Reset in the second RUN cycle aborts and clears.
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {16'd0, sum}, 32'd0);
    check("abort_carry", {31'd0, carry}, 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
    end
    check("abort_no_done", dones, 32'd0);
    run16("max_cin", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    tick();

    // Single-chunk configuration.
    run8("w8_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    run8("w8_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    run8("w8_7f_80_c", 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1);

`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    run16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    tick();
    check("ovf_hold", {31'd0, ovf}, 32'd1);
    run16("ovf_none", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
